// File: rtl/pe_drain_pkg.sv
// rtl/pe_drain_pkg.sv - shared constants, FSM state enum and FIFO entry layout for pe_drain
//
// Purpose : default widths/depth for the PE drain path, the output FIFO
//           control-state enum and the {data, sat, first} entry layout.
// Ports   : none (package).
package pe_drain_pkg;

  localparam int PE_DRAIN_IN_W  = 19;
  localparam int PE_DRAIN_OUT_W = 8;
  localparam int PE_DRAIN_DEPTH = 4;

  // Output FIFO occupancy state: empty, partially filled, full.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_e;

  // One drained result at the default output width. The FIFO stores entries
  // flattened in exactly this field order: data in the MSBs, then sat, then first.
  typedef struct packed {
    logic signed [PE_DRAIN_OUT_W-1:0] data;
    logic                             sat;
    logic                             first;
  } fifo_entry_t;

endpackage

// File: rtl/pe_drain_fifo.sv
// rtl/pe_drain_fifo.sv - in-order result FIFO with IDLE/ACTIVE/FULL control FSM
//
// Purpose : stores drained results in order; drops a push that arrives while
//           full unless the same cycle also pops.
// Ports   : CLK, RST (async, active-low)
//           push_i, wdata_i    - write request and entry
//           pop_ready_i        - consumer ready; pop = valid_o && pop_ready_i
//           rdata_o, valid_o   - head entry and its qualifier
//           drop_o             - a push was discarded this cycle
//           count_o            - current occupancy
module pe_drain_fifo
  import pe_drain_pkg::*;
#(
  parameter int W     = PE_DRAIN_OUT_W + 2,
  parameter int DEPTH = PE_DRAIN_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_ready_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic          drop_o,
  output logic [CW-1:0] count_o
);

  fifo_state_e   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          full;
  logic          pop;
  logic          push_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop     = valid_o && pop_ready_i;
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;
  assign count_d = count_q + CW'(push_ok) - CW'(pop);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic follows the occupancy after this cycle's push/pop.
  always_comb begin
    state_d = ST_ACTIVE;
    if (count_d == '0) begin
      state_d = ST_IDLE;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = ST_FULL;
    end
  end

  // Output logic
  always_comb begin
    valid_o = 1'b0;
    full    = 1'b0;
    case (state_q)
      ST_ACTIVE: valid_o = 1'b1;
      ST_FULL: begin
        valid_o = 1'b1;
        full    = 1'b1;
      end
      default: begin
        valid_o = 1'b0;
        full    = 1'b0;
      end
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: contents are only observed through valid_o.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pe_drain.sv
// rtl/pe_drain.sv - PE accumulator drain: shift, optional round, saturate, FIFO
//
// Purpose : registers PE outputs, scales them by an arithmetic right shift,
//           saturates to OUT_W bits, tags tile starts and queues results.
//           Define PE_DRAIN_ROUND_EN for round-half-up instead of truncation.
// Ports   : CLK, RST (async, active-low)
//           in_c, in_valid, in_shift, in_propagate - PE side (never stalled)
//           out_data, out_sat, out_first, out_valid, out_ready - result stream
//           ovf_clr, overflow - sticky drop flag and its clear
//           count - FIFO occupancy
module pe_drain
  import pe_drain_pkg::*;
#(
  parameter int IN_W  = PE_DRAIN_IN_W,
  parameter int OUT_W = PE_DRAIN_OUT_W,
  parameter int DEPTH = PE_DRAIN_DEPTH,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [IN_W-1:0]  in_c,
  input  logic                    in_valid,
  input  logic [3:0]              in_shift,
  input  logic                    in_propagate,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic                    out_first,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    ovf_clr,
  output logic                    overflow,
  output logic [CW-1:0]           count
);

  localparam int EW = OUT_W + 2;
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-(1 << (OUT_W-1)));

  // Stage 1 registers
  logic signed [IN_W-1:0] s1_c_q;
  logic                   s1_valid_q;
  logic [3:0]             s1_shift_q;
  logic                   s1_prop_q;

  // Tile tracking and sticky overflow
  logic last_prop_q, last_prop_d;
  logic seen_q, seen_d;
  logic ovf_q, ovf_d;

  // Stage 2 datapath
  logic signed [IN_W:0]    ext;
  logic signed [IN_W:0]    rounded;
  logic signed [IN_W:0]    shifted;
  logic signed [OUT_W-1:0] res_data;
  logic                    res_sat;
  logic                    res_first;
  logic [EW-1:0]           push_entry;

  logic [EW-1:0]           head_entry;
  logic                    fifo_valid;
  logic                    fifo_drop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_c_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_shift_q <= '0;
      s1_prop_q  <= 1'b0;
    end else begin
      s1_c_q     <= in_c;
      s1_valid_q <= in_valid;
      s1_shift_q <= in_shift;
      s1_prop_q  <= in_propagate;
    end
  end

  // One extra bit of headroom so the rounding addend can never wrap.
  assign ext = {s1_c_q[IN_W-1], s1_c_q};

`ifdef PE_DRAIN_ROUND_EN
  logic signed [IN_W:0] addend;
  assign addend  = (s1_shift_q == 4'd0) ? '0 : ((IN_W+1)'(1) << (s1_shift_q - 4'd1));
  assign rounded = ext + addend;
`else
  assign rounded = ext;
`endif

  assign shifted = rounded >>> s1_shift_q;

  always_comb begin
    res_data = shifted[OUT_W-1:0];
    res_sat  = 1'b0;
    if (shifted > SAT_MAX) begin
      res_data = SAT_MAX[OUT_W-1:0];
      res_sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res_data = SAT_MIN[OUT_W-1:0];
      res_sat  = 1'b1;
    end
  end

  // A tile starts on the first word after reset or on any propagate toggle
  // between valid words; invalid cycles do not disturb the reference.
  assign res_first = !seen_q || (s1_prop_q != last_prop_q);

  always_comb begin
    last_prop_d = last_prop_q;
    seen_d      = seen_q;
    if (s1_valid_q) begin
      last_prop_d = s1_prop_q;
      seen_d      = 1'b1;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_prop_q <= 1'b0;
      seen_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      last_prop_q <= last_prop_d;
      seen_q      <= seen_d;
      ovf_q       <= ovf_d;
    end
  end

  assign push_entry = {res_data, res_sat, res_first};

  pe_drain_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .push_i      (s1_valid_q),
    .wdata_i     (push_entry),
    .pop_ready_i (out_ready),
    .rdata_o     (head_entry),
    .valid_o     (fifo_valid),
    .drop_o      (fifo_drop),
    .count_o     (count)
  );

  // Head fields read as zero whenever nothing is queued.
  assign out_valid = fifo_valid;
  assign out_data  = fifo_valid ? head_entry[EW-1:2] : '0;
  assign out_sat   = fifo_valid && head_entry[1];
  assign out_first = fifo_valid && head_entry[0];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pe_drain.sv
// tb/tb_pe_drain.sv - self-checking bench for pe_drain with a queue-based reference model
module tb_pe_drain;

  localparam int IN_W  = 19;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b0;
  logic signed [IN_W-1:0]  in_c = '0;
  logic                    in_valid = 1'b0;
  logic [3:0]              in_shift = '0;
  logic                    in_propagate = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;
  logic                    out_first;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic                    ovf_clr = 1'b0;
  logic                    overflow;
  logic [CW-1:0]           count;

  int n_cmp = 0;
  int n_bad = 0;

  pe_drain dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_c         (in_c),
    .in_valid     (in_valid),
    .in_shift     (in_shift),
    .in_propagate (in_propagate),
    .out_data     (out_data),
    .out_sat      (out_sat),
    .out_first    (out_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ovf_clr      (ovf_clr),
    .overflow     (overflow),
    .count        (count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model state
  typedef struct {
    int data;
    bit sat;
    bit first;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  bit   m_seen;
  bit   m_last;
  bit   p_valid;
  int   p_c;
  int   p_sh;
  bit   p_prop;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scaling rule: value / 2^sh rounded toward -inf (optionally +half first), clipped.
  function automatic void model_calc(input int c, input int sh, output int d, output bit s);
    longint v;
    longint div;
    longint q;
    v   = c;
    div = longint'(1) << sh;
`ifdef PE_DRAIN_ROUND_EN
    if (sh > 0) v = v + div / 2;
`endif
    q = v / div;
    if ((v % div != 0) && (v < 0)) q = q - 1;
    s = 1'b0;
    if (q > 127) begin
      q = 127;
      s = 1'b1;
    end else if (q < -128) begin
      q = -128;
      s = 1'b1;
    end
    d = int'(q);
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_ovf   = 1'b0;
    m_seen  = 1'b0;
    m_last  = 1'b0;
    p_valid = 1'b0;
    p_c     = 0;
    p_sh    = 0;
    p_prop  = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs presented to that edge.
  function automatic void model_edge();
    bit   pop;
    bit   drop;
    ent_t e;
    pop  = (mq.size() > 0) && out_ready;
    drop = 1'b0;
    if (pop) void'(mq.pop_front());
    if (p_valid) begin
      model_calc(p_c, p_sh, e.data, e.sat);
      e.first = !m_seen || (p_prop != m_last);
      m_seen  = 1'b1;
      m_last  = p_prop;
      if (mq.size() < DEPTH) mq.push_back(e);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    p_valid = in_valid;
    p_c     = int'(in_c);
    p_sh    = int'(in_shift);
    p_prop  = in_propagate;
  endfunction

  task automatic check_model();
    chk("valid", longint'(out_valid), longint'(mq.size() > 0));
    chk("count", longint'(count), longint'(mq.size()));
    chk("overflow", longint'(overflow), longint'(m_ovf));
    if (mq.size() > 0) begin
      chk("data", longint'(out_data), longint'(mq[0].data));
      chk("sat", longint'(out_sat), longint'(mq[0].sat));
      chk("first", longint'(out_first), longint'(mq[0].first));
    end
  endtask

  // One clock: check at the falling edge, drive, then step the model at the rising edge.
  task automatic cycle(input bit v, input int c, input int sh, input bit prop,
                       input bit rdy, input bit clr);
    @(negedge CLK);
    check_model();
    in_valid     = v;
    in_c         = IN_W'(c);
    in_shift     = 4'(sh);
    in_propagate = prop;
    out_ready    = rdy;
    ovf_clr      = clr;
    @(posedge CLK);
    model_edge();
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 0, 0, 1'b0, rdy, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST          = 1'b0;
    in_valid     = 1'b0;
    in_c         = '0;
    in_shift     = '0;
    in_propagate = 1'b0;
    out_ready    = 1'b0;
    ovf_clr      = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_count", longint'(count), 0);
    chk("rst_ovf", longint'(overflow), 0);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_sat", longint'(out_sat), 0);
    chk("rst_first", longint'(out_first), 0);
    RST = 1'b1;
  endtask

  // Single word through an empty FIFO: head appears two clocks after the input.
  task automatic directed(input int c, input int sh, input int ed, input int es, input string tag);
    cycle(1'b1, c, sh, 1'b0, 1'b1, 1'b0);
    #1 chk({tag, "_lat1"}, longint'(out_valid), 0);
    idle(1'b1);
    #1;
    chk({tag, "_lat2"}, longint'(out_valid), 1);
    chk({tag, "_data"}, longint'(out_data), longint'(ed));
    chk({tag, "_sat"}, longint'(out_sat), longint'(es));
    idle(1'b1);
  endtask

  bit props [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit firsts[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    bit v;
    bit rdy;
    bit clr;
    bit prop;
    int c;
    int sh;

    model_clear();
    apply_reset();

    directed(256, 4, 16, 0, "scale256");
    directed(-1000, 0, -128, 1, "satneg");
    directed(300, 1, 127, 1, "satpos");
`ifdef PE_DRAIN_ROUND_EN
    directed(24, 4, 2, 0, "rnd_p24");
    directed(-24, 4, -1, 0, "rnd_m24");
`else
    directed(24, 4, 1, 0, "trunc_p24");
    directed(-24, 4, -2, 0, "trunc_m24");
`endif

    // Backpressure: five words into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) cycle(1'b1, i, 0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    #1;
    chk("full_count", longint'(count), 4);
    chk("full_ovf", longint'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", longint'(out_data), longint'(i));
      idle(1'b1);
      #1;
    end
    chk("drain_empty", longint'(out_valid), 0);
    chk("ovf_sticky", longint'(overflow), 1);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    #1 chk("ovf_clr", longint'(overflow), 0);

    // Tile-start marking right after reset.
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 10 + k, 0, props[k], 1'b1, 1'b0);
      #1;
      if (k >= 1) chk("tile_first", longint'(out_first), longint'(firsts[k-1]));
    end
    idle(1'b1);
    #1 chk("tile_first_last", longint'(out_first), longint'(firsts[4]));
    idle(1'b1);

    // Reset in the middle of a burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, 40 + i, 0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    #1;
    chk("pre_rst_count", longint'(count), 3);
    chk("pre_rst_ovf", longint'(overflow), 1);
    #2;
    RST = 1'b0;
    #1;
    chk("midrst_valid", longint'(out_valid), 0);
    chk("midrst_count", longint'(count), 0);
    chk("midrst_ovf", longint'(overflow), 0);
    model_clear();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    cycle(1'b1, 5, 0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    #1;
    chk("post_rst_valid", longint'(out_valid), 1);
    chk("post_rst_first", longint'(out_first), 1);
    idle(1'b1);

    // Randomized traffic with bursts of backpressure.
    apply_reset();
    prop = 1'b0;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0) c = int'($urandom_range(0, 4000)) - 2000;
      else c = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
      sh = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) prop = ~prop;
      rdy = ((n % 64) < 20) ? 1'b0 : ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cycle(v, c, sh, prop, rdy, clr);
    end
    for (int n = 0; n < 8; n++) idle(1'b1);
    @(negedge CLK);
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
